// File: rtl/matmul_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : matmul_pkg                                                   |
// | Description : Shared types and constants for the matrix-multiply           |
// |               sequencer: FSM state encoding, dimension field width,        |
// |               control-register bit positions and the field decode helper.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package matmul_pkg;

  // Width of each dimension field; a field value f encodes dimension f + 1.
  localparam int DIM_W = 2;

  // Bit positions of the sequencer fields inside the 16-bit control register.
  localparam int c_CTRL_START_BIT = 0;
  localparam int c_CTRL_N_LSB     = 8;
  localparam int c_CTRL_N_MSB     = 9;
  localparam int c_CTRL_K_LSB     = 10;
  localparam int c_CTRL_K_MSB     = 11;
  localparam int c_CTRL_M_LSB     = 12;
  localparam int c_CTRL_M_MSB     = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Decode a dimension field into the real dimension (1 .. 2^DIM_W).
  function automatic logic [DIM_W:0] dim_decode(input logic [DIM_W-1:0] field);
    return {1'b0, field} + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : matmul_seq_if                                                |
// | Description : Control/operand/write-back bundle of the matmul sequencer.   |
// |   master : sequencer side (drives busy/done/issue/write-back signals)      |
// |   slave  : control register + datapath side (drives start/dims/stall)      |
// | Signals     : start_i, dim_n_i, dim_k_i, dim_m_i, stall_i (to sequencer);  |
// |               busy_o, done_o, clear_start_o, err_o, rd_en_o, a_row_o,      |
// |               a_col_o, b_row_o, b_col_o, mac_first_o, c_wr_en_o, c_row_o,  |
// |               c_col_o (from sequencer); cycle_cnt_o only when              |
// |               MATMUL_SEQ_PERF_EN is defined.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface matmul_seq_if
  import matmul_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic [DIM_W-1:0] dim_n_i;
  logic [DIM_W-1:0] dim_k_i;
  logic [DIM_W-1:0] dim_m_i;
  logic             stall_i;
  logic             busy_o;
  logic             done_o;
  logic             clear_start_o;
  logic             err_o;
  logic             rd_en_o;
  logic [DIM_W-1:0] a_row_o;
  logic [DIM_W-1:0] a_col_o;
  logic [DIM_W-1:0] b_row_o;
  logic [DIM_W-1:0] b_col_o;
  logic             mac_first_o;
  logic             c_wr_en_o;
  logic [DIM_W-1:0] c_row_o;
  logic [DIM_W-1:0] c_col_o;
`ifdef MATMUL_SEQ_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_o;
`endif

  modport master (
    input  start_i, dim_n_i, dim_k_i, dim_m_i, stall_i,
    output busy_o, done_o, clear_start_o, err_o, rd_en_o,
           a_row_o, a_col_o, b_row_o, b_col_o, mac_first_o,
           c_wr_en_o, c_row_o, c_col_o
`ifdef MATMUL_SEQ_PERF_EN
    , output cycle_cnt_o
`endif
  );

  modport slave (
    output start_i, dim_n_i, dim_k_i, dim_m_i, stall_i,
    input  busy_o, done_o, clear_start_o, err_o, rd_en_o,
           a_row_o, a_col_o, b_row_o, b_col_o, mac_first_o,
           c_wr_en_o, c_row_o, c_col_o
`ifdef MATMUL_SEQ_PERF_EN
    , input cycle_cnt_o
`endif
  );

endinterface
`default_nettype wire

// File: rtl/matmul_seq_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : matmul_seq_delay                                             |
// | Description : DEPTH-stage shift register carrying {valid, row, col} of a   |
// |               C element alongside the MAC pipeline. Advances every cycle.  |
// | Ports       : clk_i, rst_ni (async active-low)                             |
// |               valid_i/row_i/col_i : stage-0 input                          |
// |               valid_o/row_o/col_o : last-stage output                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module matmul_seq_delay
  import matmul_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [DIM_W-1:0] row_i,
  input  logic [DIM_W-1:0] col_i,
  output logic             valid_o,
  output logic [DIM_W-1:0] row_o,
  output logic [DIM_W-1:0] col_o
);

  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0][DIM_W-1:0] r_row;
  logic [DEPTH-1:0][DIM_W-1:0] r_col;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_valid <= '0;
          r_row   <= '0;
          r_col   <= '0;
        end else begin
          r_valid <= valid_i;
          r_row   <= row_i;
          r_col   <= col_i;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_valid <= '0;
          r_row   <= '0;
          r_col   <= '0;
        end else begin
          r_valid <= {r_valid[DEPTH-2:0], valid_i};
          r_row   <= {r_row[DEPTH-2:0], row_i};
          r_col   <= {r_col[DEPTH-2:0], col_i};
        end
      end
    end
  endgenerate

  assign valid_o = r_valid[DEPTH-1];
  assign row_o   = r_row[DEPTH-1];
  assign col_o   = r_col[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/matmul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : matmul_seq                                                   |
// | Description : Output-stationary i/j/kk loop sequencer for C = A * B.       |
// |               Issues operand reads and MAC control, tracks the MAC         |
// |               latency with a delay line and emits C write-backs.           |
// |               Flow: IDLE -> ISSUE -> DRAIN (PIPE_LAT cycles) -> DONE.      |
// | Ports       : clk_i, rst_ni (async active-low), bus (matmul_seq_if.master) |
// | Options     : MATMUL_SEQ_PERF_EN adds bus.cycle_cnt_o, a saturating count  |
// |               of busy cycles cleared on each accepted start.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int PIPE_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  matmul_seq_if.master  bus
);

  localparam int c_DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_e               r_state;
  logic                 r_start_q;
  logic [DIM_W-1:0]     r_dim_n;
  logic [DIM_W-1:0]     r_dim_k;
  logic [DIM_W-1:0]     r_dim_m;
  logic [DIM_W-1:0]     r_i;
  logic [DIM_W-1:0]     r_j;
  logic [DIM_W-1:0]     r_kk;
  logic [c_DRAIN_W-1:0] r_drain;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_clear;
  logic                 r_err;

  logic                 w_start_rise;
  logic                 w_issue;
  logic                 w_last_kk;
  logic                 w_last_j;
  logic                 w_last_i;
  logic                 w_wb_valid;
  logic                 w_wr_en;
  logic [DIM_W-1:0]     w_wr_row;
  logic [DIM_W-1:0]     w_wr_col;

  assign w_start_rise = bus.start_i & ~r_start_q;
  assign w_issue      = (r_state == ISSUE) & ~bus.stall_i;
  assign w_last_kk    = (r_kk == r_dim_k);
  assign w_last_j     = (r_j == r_dim_m);
  assign w_last_i     = (r_i == r_dim_n);
  // The C element is complete once its final kk product has been issued.
  assign w_wb_valid   = w_issue & w_last_kk;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      // Starts high so a start bit held across reset is not seen as an edge.
      r_start_q <= 1'b1;
      r_dim_n   <= '0;
      r_dim_k   <= '0;
      r_dim_m   <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_kk      <= '0;
      r_drain   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_clear   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_start_q <= bus.start_i;
      r_err     <= w_start_rise & (r_state != IDLE);
      r_done    <= 1'b0;
      r_clear   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_rise) begin
            r_dim_n <= bus.dim_n_i;
            r_dim_k <= bus.dim_k_i;
            r_dim_m <= bus.dim_m_i;
            r_i     <= '0;
            r_j     <= '0;
            r_kk    <= '0;
            r_busy  <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_issue) begin
            if (w_last_kk) begin
              r_kk <= '0;
              if (w_last_j) begin
                r_j <= '0;
                if (w_last_i) begin
                  r_i     <= '0;
                  r_drain <= '0;
                  r_state <= DRAIN;
                end else begin
                  r_i <= r_i + 1'b1;
                end
              end else begin
                r_j <= r_j + 1'b1;
              end
            end else begin
              r_kk <= r_kk + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Exactly PIPE_LAT cycles: the last write-back leaves the delay line
          // during the final DRAIN cycle.
          if (r_drain == c_DRAIN_W'(PIPE_LAT - 1)) begin
            r_done  <= 1'b1;
            r_clear <= 1'b1;
            r_state <= DONE;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  matmul_seq_delay #(
    .DEPTH   (PIPE_LAT)
  ) u_delay (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (w_wb_valid),
    .row_i   (r_i),
    .col_i   (r_j),
    .valid_o (w_wr_en),
    .row_o   (w_wr_row),
    .col_o   (w_wr_col)
  );

  assign bus.busy_o        = r_busy;
  assign bus.done_o        = r_done;
  assign bus.clear_start_o = r_clear;
  assign bus.err_o         = r_err;
  assign bus.rd_en_o       = w_issue;
  assign bus.a_row_o       = r_i;
  assign bus.a_col_o       = r_kk;
  assign bus.b_row_o       = r_kk;
  assign bus.b_col_o       = r_j;
  assign bus.mac_first_o   = w_issue & (r_kk == '0);
  assign bus.c_wr_en_o     = w_wr_en;
  assign bus.c_row_o       = w_wr_row;
  assign bus.c_col_o       = w_wr_col;

`ifdef MATMUL_SEQ_PERF_EN
  logic [CNT_W-1:0] r_cycle_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cycle_cnt <= '0;
    end else if ((r_state == IDLE) && w_start_rise) begin
      r_cycle_cnt <= '0;
    end else if (r_busy && (r_cycle_cnt != {CNT_W{1'b1}})) begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
    end
  end

  assign bus.cycle_cnt_o = r_cycle_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_matmul_seq                                                |
// | Description : Directed self-checking bench for matmul_seq (PIPE_LAT = 2).  |
// |               Cycle c spans posedge c .. posedge c+1; inputs change 1 ns   |
// |               after the posedge, outputs are sampled on the negedge.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_matmul_seq;
  import matmul_pkg::*;

  localparam int c_PIPE_LAT = 2;
  localparam int c_CNT_W    = 16;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_iss;
  int   n_wr;
  int   t;
  int   w;
  int   wr_row_2x2 [4] = '{0, 0, 1, 1};
  int   wr_col_2x2 [4] = '{0, 1, 0, 1};

  matmul_seq_if #(.CNT_W(c_CNT_W)) bus ();

  matmul_seq #(
    .PIPE_LAT (c_PIPE_LAT),
    .CNT_W    (c_CNT_W)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic chk_ctrl(input bit e_rd, input bit e_first, input bit e_wr,
                          input bit e_busy, input bit e_done, input bit e_err);
    chk("rd_en", 32'(bus.rd_en_o), 32'(e_rd));
    chk("mac_first", 32'(bus.mac_first_o), 32'(e_first));
    chk("c_wr_en", 32'(bus.c_wr_en_o), 32'(e_wr));
    chk("busy", 32'(bus.busy_o), 32'(e_busy));
    chk("done", 32'(bus.done_o), 32'(e_done));
    chk("clear_start", 32'(bus.clear_start_o), 32'(e_done));
    chk("err", 32'(bus.err_o), 32'(e_err));
  endtask

  task automatic chk_addr(input int i, input int j, input int kk);
    chk("a_row", 32'(bus.a_row_o), i);
    chk("a_col", 32'(bus.a_col_o), kk);
    chk("b_row", 32'(bus.b_row_o), kk);
    chk("b_col", 32'(bus.b_col_o), j);
  endtask

  task automatic chk_wr_addr(input int r, input int c);
    chk("c_row", 32'(bus.c_row_o), r);
    chk("c_col", 32'(bus.c_col_o), c);
  endtask

  task automatic chk_all_zero();
    chk_ctrl(0, 0, 0, 0, 0, 0);
    chk_addr(0, 0, 0);
    chk_wr_addr(0, 0);
`ifdef MATMUL_SEQ_PERF_EN
    chk("cycle_cnt_rst", 32'(bus.cycle_cnt_o), 0);
`endif
  endtask

  // One cycle with start low, then raise start in cycle 0 with the given fields.
  task automatic begin_seq(input logic [DIM_W-1:0] n, input logic [DIM_W-1:0] k,
                           input logic [DIM_W-1:0] m);
    adv();
    bus.start_i = 1'b0;
    adv();
    bus.start_i = 1'b1;
    bus.dim_n_i = n;
    bus.dim_k_i = k;
    bus.dim_m_i = m;
    cyc = 0;
    smp();
    chk("busy_c0", 32'(bus.busy_o), 0);
    chk("rd_en_c0", 32'(bus.rd_en_o), 0);
  endtask

  initial begin
    rst_ni      = 1'b0;
    bus.start_i = 1'b0;
    bus.dim_n_i = '0;
    bus.dim_k_i = '0;
    bus.dim_m_i = '0;
    bus.stall_i = 1'b0;

    // Reset state
    adv();
    smp();
    chk_all_zero();
    adv();
    rst_ni = 1'b1;
    adv();

    // 1x1x1: issue c1, write c3 at (0,0), done c4, busy c1..c4
    begin_seq(2'd0, 2'd0, 2'd0);
    for (int c = 1; c <= 5; c++) begin
      adv();
      smp();
      chk_ctrl(c == 1, c == 1, c == 3, (c >= 1) && (c <= 4), c == 4, 0);
      if (c == 1) chk_addr(0, 0, 0);
      if (c == 3) chk_wr_addr(0, 0);
`ifdef MATMUL_SEQ_PERF_EN
      if (c == 5) chk("cycle_cnt_1x1", 32'(bus.cycle_cnt_o), 4);
`endif
    end
    bus.start_i = 1'b0;

    // 2x3 * 3x2: issues c1..c12, writes c5/8/11/14, done c15
    begin_seq(2'd1, 2'd2, 2'd1);
    for (int c = 1; c <= 16; c++) begin
      adv();
      smp();
      t = c - 1;
      chk_ctrl(c <= 12, (c <= 12) && (t % 3 == 0), c inside {5, 8, 11, 14},
               c <= 15, c == 15, 0);
      if (c <= 12) chk_addr(t / 6, (t / 3) % 2, t % 3);
      if (c inside {5, 8, 11, 14}) begin
        w = (c - 5) / 3;
        chk_wr_addr(wr_row_2x2[w], wr_col_2x2[w]);
      end
    end
    bus.start_i = 1'b0;

    // Same with stall in c2..c3 (and ignored stall in DRAIN c15..c16)
    begin_seq(2'd1, 2'd2, 2'd1);
    for (int c = 1; c <= 18; c++) begin
      adv();
      bus.stall_i = (c == 2) || (c == 3) || (c == 15) || (c == 16);
      smp();
      t = (c == 1) ? 0 : c - 3;
      chk_ctrl((c == 1) || ((c >= 4) && (c <= 14)),
               ((c == 1) || ((c >= 4) && (c <= 14))) && (t % 3 == 0),
               c inside {7, 10, 13, 16}, c <= 17, c == 17, 0);
      if ((c == 1) || ((c >= 4) && (c <= 14))) chk_addr(t / 6, (t / 3) % 2, t % 3);
      if (c inside {7, 10, 13, 16}) begin
        w = (c - 7) / 3;
        chk_wr_addr(wr_row_2x2[w], wr_col_2x2[w]);
      end
`ifdef MATMUL_SEQ_PERF_EN
      if (c == 18) chk("cycle_cnt_stall", 32'(bus.cycle_cnt_o), 17);
`endif
    end
    bus.stall_i = 1'b0;
    bus.start_i = 1'b0;

    // Start re-pulsed while busy: err in c6 only, sequence unchanged, no restart
    begin_seq(2'd1, 2'd2, 2'd1);
    for (int c = 1; c <= 18; c++) begin
      adv();
      if (c == 4) bus.start_i = 1'b0;
      if (c == 5) bus.start_i = 1'b1;
      smp();
      t = c - 1;
      chk_ctrl(c <= 12, (c <= 12) && (t % 3 == 0), c inside {5, 8, 11, 14},
               c <= 15, c == 15, c == 6);
      if (c <= 12) chk_addr(t / 6, (t / 3) % 2, t % 3);
    end
    bus.start_i = 1'b0;

    // Asynchronous reset in cycle 6 of a 4x4x4 run, start held high after
    begin_seq(2'd3, 2'd3, 2'd3);
    for (int c = 1; c <= 5; c++) begin
      adv();
      smp();
      chk("rd_en_pre_rst", 32'(bus.rd_en_o), 1);
      chk_addr(0, (c - 1) / 4, (c - 1) % 4);
    end
    adv();
    rst_ni = 1'b0;
    #1;
    chk_all_zero();
    adv();
    smp();
    chk_all_zero();
    adv();
    rst_ni = 1'b1;
    smp();
    chk_all_zero();
    for (int c = 0; c < 4; c++) begin
      adv();
      smp();
      chk_ctrl(0, 0, 0, 0, 0, 0);
    end
    bus.start_i = 1'b0;

    // 4x4x4: 64 issues, 16 row-major writes c6..c66, done c67
    begin_seq(2'd3, 2'd3, 2'd3);
    n_iss = 0;
    n_wr  = 0;
    for (int c = 1; c <= 68; c++) begin
      adv();
      smp();
      t = c - 1;
      chk_ctrl(c <= 64, (c <= 64) && (t % 4 == 0),
               (c >= 6) && (c <= 66) && ((c - 6) % 4 == 0), c <= 67, c == 67, 0);
      if (c <= 64) chk_addr(t / 16, (t / 4) % 4, t % 4);
      if ((c >= 6) && (c <= 66) && ((c - 6) % 4 == 0)) begin
        w = (c - 6) / 4;
        chk_wr_addr(w / 4, w % 4);
      end
      n_iss += int'(bus.rd_en_o);
      n_wr  += int'(bus.c_wr_en_o);
`ifdef MATMUL_SEQ_PERF_EN
      if (c == 68) chk("cycle_cnt_4x4", 32'(bus.cycle_cnt_o), 67);
`endif
    end
    chk("issue_total", 32'(n_iss), 64);
    chk("write_total", 32'(n_wr), 16);
    bus.start_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
